instr_fetch_unit: RTL

//  Instruction fetch stage driven by the control FSM's IR_load strobe. Holds the PC,

---
 rtl/tron_pkg.sv | 25 ++
 rtl/pc_next_calc.sv | 29 ++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/tron_pkg.sv
// Shared constants for the TRON fetch stage: opcodes, fetch FSM encoding, PC select codes.
package tron_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LD  = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_ST  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_BR  = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'hD;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] PC_SEL_INC  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_JMP  = 2'd2;
  localparam logic [1:0] PC_SEL_HOLD = 2'd3;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: increment, PC-relative branch on sign-extended imm, absolute jump, hold.
module pc_next_calc
  import tron_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        imm,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] pc_next_c
);

  logic [ADDR_W-1:0] disp_c;

  assign disp_c = {{(ADDR_W - 8){imm[7]}}, imm};

  // Results wrap modulo 2^ADDR_W by truncation.
  always_comb begin
    pc_next_c = pc;
    case (pc_sel)
      PC_SEL_INC: pc_next_c = pc + ADDR_W'(1);
      PC_SEL_BR:  pc_next_c = pc + disp_c;
      PC_SEL_JMP: pc_next_c = jmp_target;
      default:    pc_next_c = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake, IR and field decode.
// Optional WAIT-state timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import tron_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IR_load,
  input  logic              pc_en,
  input  logic [1:0]        pc_sel,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic [3:0]        opcode,
  output logic [3:0]        rdest,
  output logic [3:0]        opext,
  output logic [3:0]        rsrc,
  output logic [7:0]        imm,
  output logic              fetch_err
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] pc_next_c;
  logic              timeout_c;

  assign opcode = ir[15:12];
  assign rdest  = ir[11:8];
  assign opext  = ir[7:4];
  assign rsrc   = ir[3:0];
  assign imm    = ir[7:0];

  pc_next_calc #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_calc (
    .pc        (pc),
    .imm       (ir[7:0]),
    .jmp_target(jmp_target),
    .pc_sel    (pc_sel),
    .pc_next_c (pc_next_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (IR_load) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: if (mem_ready || timeout_c) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      fetch_busy <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      mem_rd     <= (state_nxt == ST_REQ) || (state_nxt == ST_WAIT);
      fetch_busy <= (state_nxt == ST_REQ) || (state_nxt == ST_WAIT);
      fetch_done <= (state_nxt == ST_DONE);
      if ((state == ST_IDLE) && IR_load) mem_addr <= pc;
      if ((state == ST_IDLE) && pc_en) pc <= pc_next_c;
      if (state == ST_WAIT) begin
        if (mem_ready) ir <= mem_rdata;
        else if (timeout_c) ir <= DATA_W'(NOP_INSTR);
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_c = (state == ST_WAIT) && !mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Counter is cleared in REQ so every WAIT entry starts from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == ST_REQ) wait_cnt <= '0;
      else if ((state == ST_WAIT) && !mem_ready && !timeout_c) wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout_c) fetch_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_c          = 1'b0;
  assign fetch_err          = 1'b0;
`endif

endmodule
